rr_stream_mux: RTL and testbench
================================

Name: rr_stream_mux

Overview:
Parametrised N-channel, W-bit stream multiplexer; the next generation of the team's combinational 4:1 mux. It adds:
- valid/ready handshakes on every input and the output;
- a registered single-entry output stage;
- a runtime mode choice between software-fixed select and fair round-robin arbitration.

It sits between multiple producer datapaths and one shared consumer, such as an ALU operand bus or a shared memory write port.

Parameters:
N_CH, 4, number of input channels (>=2).
W, 8, data width per channel in bits.
SEL_W, $clog2(N_CH), width of channel index fields (derived; do not override).

Ports:
clk  input  1  rising-edge clock, single clock domain.
rst_n  input  1  asynchronous active-low reset.
in_data  input  N_CH*W  channel k occupies bits [k*W +: W].
in_valid  input  N_CH  per-channel data valid.
in_ready  output  N_CH  per-channel accept; at most one bit set per cycle.
mode  input  1  0 = fixed select, 1 = round-robin.
sel  input  SEL_W  channel selected in fixed mode; values >= N_CH select nothing.
out_data  output  W  registered output data.
out_valid  output  1  output register holds a beat.
out_ch  output  SEL_W  source channel index of the beat in out_data.
out_ready  input  1  consumer accept.

Interface note: one clock, clk; reset is rst_n, asynchronous assert, active-low. Deassertion is synchronised externally.

Behaviour:
- Reset (rst_n=0, immediate): out_valid=0, out_data=0, out_ch=0, round-robin pointer ptr=0. in_ready is all zero while in reset.
- Output transfer: occurs when out_valid && out_ready.
- can_load = !out_valid || out_ready. Full throughput: 1 beat/cycle when out_ready is held high.
- Grant, combinational from in_valid, mode, sel and ptr:
  - Fixed mode: grant = sel if sel < N_CH and in_valid[sel]; otherwise no grant.
  - Round-robin mode: grant is the first k with in_valid[k], scanning ptr, ptr+1, ... modulo N_CH.
- in_ready[k] = can_load && (grant == k). in_ready never depends on in_valid[k] of a non-granted channel.
- Input transfer on channel k: in_valid[k] && in_ready[k].
  - Next edge: out_data <= in_data[k], out_ch <= k, out_valid <= 1.
  - Latency: input transfer at edge t → data visible on out_data after edge t, consumable at edge t+1.
- Output transfer with no input transfer in the same cycle: out_valid <= 0. out_data and out_ch hold their last values.
- Simultaneous output transfer and input transfer: the register is replaced with the new beat; out_valid stays 1.
- Backpressure: while out_valid && !out_ready, out_data and out_ch are stable and in_ready is all zero.
- Pointer update:
  - Only on an input transfer in round-robin mode: ptr <= (k == N_CH-1) ? 0 : k+1 (wrap-around).
  - Fixed-mode transfers leave ptr unchanged.
  - The pointer keeps its value across mode changes.
- mode and sel may change on any cycle. The change affects only the grant of that cycle; a beat already in the output register is unaffected.
- Producer rule: once in_valid[k] is raised it is held until transfer. If the mode switches away, the channel waits; it is not dropped.
- No valid inputs: no grant, in_ready all zero, output drains normally.
- Reset mid-operation: any beat held in the output register is discarded and ptr returns to 0.

Decomposition:
- Shared package rr_mux_pkg:
  - mode encodings MODE_FIXED=1'b0, MODE_RR=1'b1;
  - a function for the index width (clog2), reused by the team's other parametrised blocks.
- One sub-module, rr_arbiter:
  - parameter N_CH;
  - inputs req[N_CH], ptr[SEL_W], en;
  - outputs gnt_vld and gnt_idx[SEL_W];
  - purely combinational rotate-priority encoder.
- The top level owns the ptr register, the fixed-mode override, the output register and the handshakes.

Test Plan:
1. Reset check: assert rst_n=0 mid-stream with out_valid=1 → out_valid=0, out_data=0, out_ch=0 immediately. After release with mode=1 and all channels valid, the first grant is ch0.
2. Round-robin fairness (N_CH=4, W=8): in_valid=4'b1111 held, channel k data = 8'hA0+k, out_ready=1 → out_ch sequence 0,1,2,3,0,1 and out_data A0,A1,A2,A3,A0,A1 on consecutive cycles.
3. Round-robin skip and wrap: in_valid=4'b1010 held → out_ch alternates 1,3,1,3. Then drop ch3 → ch1 only, granted every cycle.
4. Fixed mode and out-of-range select: mode=0, sel=2, in_valid=4'b1111 → only in_ready[2] toggles and out_ch=2 every beat. sel=3 with in_valid[3]=0 → no transfers and out_valid drops after the drain. On an N_CH=3 build, sel=3 → no grant.
5. Backpressure: out_ready=0 for 5 cycles with a beat held (out_data=8'h5C) → out_data and out_ch stable, in_ready=0. Raise out_ready → the next beat loads the same cycle with no bubble.
6. Mode switch mid-stream: in round-robin after a ch1 transfer (ptr=2), switch to mode=0, sel=0 for 3 beats, then back to mode=1 → the next grant is ch2.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// Shared definitions for the stream-mux family: mode encodings and the
// index-width helper used to size channel index fields.
package rr_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Smallest width that can index n entries; never less than one bit.
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority encoder: grants the first requester found
// scanning from ptr upward with wrap-around.
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int N_CH = 4,
    localparam int SEL_W = idx_width(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             en,
    output logic             gnt_vld,
    output logic [SEL_W-1:0] gnt_idx
);

    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        int j;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        j       = 0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            j       = (int'(ptr) + i) % N_CH;
            gnt_vld = (en && req[SEL_W'(j)]) ? 1'b1 : gnt_vld;
            gnt_idx = (en && req[SEL_W'(j)]) ? SEL_W'(j) : gnt_idx;
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream multiplexer with a registered single-entry
// output stage and a runtime choice of fixed select or round-robin.
module rr_stream_mux
    import rr_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int W     = 8,
    parameter int SEL_W = idx_width(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH*W-1:0] in_data,
    input  logic [N_CH-1:0]   in_valid,
    output logic [N_CH-1:0]   in_ready,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel,
    output logic [W-1:0]      out_data,
    output logic              out_valid,
    output logic [SEL_W-1:0]  out_ch,
    input  logic              out_ready
);

    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;

    logic             rr_vld_s;
    logic [SEL_W-1:0] rr_idx_s;
    logic             gnt_vld_s;
    logic [SEL_W-1:0] gnt_idx_s;
    logic             can_load_s;
    logic             in_xfer_s;
    logic [W-1:0]     chan_s [N_CH];

    for (genvar k = 0; k < N_CH; k++) begin : g_chan
        assign chan_s[k] = in_data[k*W +: W];
    end

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req     (in_valid),
        .ptr     (ptr_q),
        .en      (mode == MODE_RR),
        .gnt_vld (rr_vld_s),
        .gnt_idx (rr_idx_s)
    );

    // Grant selection: arbiter result in round-robin, software select otherwise.
    always_comb begin
        gnt_vld_s = 1'b0;
        gnt_idx_s = '0;
        if (mode == MODE_RR) begin
            gnt_vld_s = rr_vld_s;
            gnt_idx_s = rr_idx_s;
        end else if (int'(sel) < N_CH) begin
            gnt_vld_s = in_valid[sel];
            gnt_idx_s = sel;
        end else begin
            gnt_vld_s = 1'b0;
            gnt_idx_s = '0;
        end
    end

    // rst_n gates the handshake so nothing is accepted while reset is held.
    assign can_load_s = !out_valid_q || out_ready;
    assign in_xfer_s  = rst_n && can_load_s && gnt_vld_s;

    // One-hot accept towards the granted producer only.
    always_comb begin
        in_ready = '0;
        if (in_xfer_s) begin
            in_ready[gnt_idx_s] = 1'b1;
        end else begin
            in_ready = '0;
        end
    end

    // Output register and pointer next-state.
    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (in_xfer_s) begin
            out_data_d  = chan_s[gnt_idx_s];
            out_ch_d    = gnt_idx_s;
            out_valid_d = 1'b1;
            if (mode == MODE_RR) begin
                ptr_d = (gnt_idx_s == SEL_W'(N_CH - 1)) ? '0 : gnt_idx_s + SEL_W'(1);
            end else begin
                ptr_d = ptr_q;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; reset discards any held beat and rewinds the pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Scoreboard bench for rr_stream_mux: directed scenarios plus randomized
// traffic checked against a queue-based reference of the grant rules.
module tb_rr_stream_mux;
    import rr_mux_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N*W-1:0] in_data;
    logic [N-1:0]  in_valid;
    logic [N-1:0]  in_ready;
    logic          mode;
    logic [SW-1:0] sel;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic [SW-1:0] out_ch;
    logic          out_ready;

    logic [3*W-1:0] in_data3;
    logic [2:0]     in_valid3;
    logic [2:0]     in_ready3;
    logic           mode3;
    logic [1:0]     sel3;
    logic [W-1:0]   out_data3;
    logic           out_valid3;
    logic [1:0]     out_ch3;
    logic           out_ready3;

    rr_stream_mux #(.N_CH(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_valid(out_valid), .out_ch(out_ch), .out_ready(out_ready)
    );

    rr_stream_mux #(.N_CH(3), .W(W)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_data(out_data3),
        .out_valid(out_valid3), .out_ch(out_ch3), .out_ready(out_ready3)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  d;
        logic [SW-1:0] ch;
    } beat_t;

    beat_t sbq[$];
    beat_t ch_log[$];
    int    n_cmp = 0;
    int    n_err = 0;
    logic  m_full;
    int    m_ptr;
    int    last_xfer;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference grant: fixed select or first valid channel scanning from p.
    function automatic int ref_grant(logic [N-1:0] v, logic md, int s, int p);
        if (md == MODE_FIXED) return (s < N && v[s]) ? s : -1;
        for (int i = 0; i < N; i++) if (v[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    task automatic set_data(int k, logic [W-1:0] v);
        in_data[k*W +: W] = v;
    endtask

    // One cycle: check handshake, advance the model at the edge, return at negedge.
    task automatic tick();
        int g;
        logic [N-1:0] er;
        #1;
        g  = ref_grant(in_valid, mode, int'(sel), m_ptr);
        er = '0;
        if ((!m_full || out_ready) && g >= 0) er[g] = 1'b1;
        chk("in_ready", 64'(in_ready), 64'(er));
        chk("out_valid", 64'(out_valid), 64'(m_full));
        @(posedge clk);
        last_xfer = -1;
        if (er != '0) begin
            sbq.push_back('{d: in_data[g*W +: W], ch: SW'(g)});
            last_xfer = g;
            if (mode == MODE_RR) m_ptr = (g + 1) % N;
            m_full = 1'b1;
        end else if (m_full && out_ready) begin
            m_full = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_ch", 64'(out_ch), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        sbq.delete();
        ch_log.delete();
        m_full = 1'b0;
        m_ptr  = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_log(string nm, int i, int exp_ch, int exp_d);
        if (i >= ch_log.size()) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s[%0d]: beat missing, got %0d beats", nm, i, ch_log.size());
        end else begin
            chk(nm, 64'(ch_log[i].ch), 64'(exp_ch));
            if (exp_d >= 0) chk(nm, 64'(ch_log[i].d), 64'(exp_d));
        end
    endtask

    // Monitor: every presented beat must match the scoreboard head.
    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_beat: got ch %0d data %0h, expected none", out_ch, out_data);
            end else begin
                chk("mon_out_data", 64'(out_data), 64'(sbq[0].d));
                chk("mon_out_ch", 64'(out_ch), 64'(sbq[0].ch));
                if (out_ready) begin
                    ch_log.push_back('{d: out_data, ch: out_ch});
                    void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        mode = MODE_RR; sel = '0; out_ready = 1'b1; in_valid = '0; in_data = '0;
        mode3 = MODE_FIXED; sel3 = '0; out_ready3 = 1'b1; in_valid3 = '0; in_data3 = '0;
        m_full = 1'b0; m_ptr = 0; last_xfer = -1;
        @(negedge clk);
        chk("init_out_valid", 64'(out_valid), 64'd0);
        chk("init_out_data", 64'(out_data), 64'd0);
        chk("init_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;

        // Mid-stream reset, then round-robin fairness from ptr=0.
        in_valid = 4'b1111;
        for (int k = 0; k < N; k++) set_data(k, 8'hA0 + 8'(k));
        tick(); tick();
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        do_reset();
        repeat (7) tick();
        for (int i = 0; i < 6; i++) chk_log("rr_fair", i, i % 4, 'hA0 + i % 4);

        // Skip and wrap over idle channels, then a single requester.
        do_reset();
        in_valid = 4'b1010;
        repeat (4) tick();
        in_valid = 4'b0010;
        repeat (4) tick();
        for (int i = 0; i < 7; i++) chk_log("rr_skip", i, (i < 4 && i % 2 == 1) ? 3 : 1, -1);

        // Fixed select.
        do_reset();
        mode = MODE_FIXED; sel = 2'd2; in_valid = 4'b1111;
        repeat (5) tick();
        for (int i = 0; i < 4; i++) chk_log("fixed_sel", i, 2, 'hA2);

        // Select of an idle channel: register drains and stays empty.
        do_reset();
        in_valid = 4'b0111; sel = 2'd2;
        tick();
        sel = 2'd3;
        repeat (3) tick();
        chk("drain_out_valid", 64'(out_valid), 64'd0);
        chk_log("drain_beat", 0, 2, 'hA2);

        // Backpressure with a held beat, then no-bubble reload.
        do_reset();
        sel = 2'd1; in_valid = 4'b0010; set_data(1, 8'h5C); out_ready = 1'b0;
        tick();
        set_data(1, 8'h77);
        repeat (5) begin
            tick();
            chk("bp_data", 64'(out_data), 64'h5C);
            chk("bp_ch", 64'(out_ch), 64'd1);
        end
        out_ready = 1'b1;
        tick();
        chk("nobubble_data", 64'(out_data), 64'h77);
        chk("nobubble_valid", 64'(out_valid), 64'd1);
        in_valid = '0;
        tick(); tick();

        // Mode switch keeps the round-robin pointer.
        do_reset();
        mode = MODE_RR; in_valid = 4'b1111;
        for (int k = 0; k < N; k++) set_data(k, 8'hA0 + 8'(k));
        tick(); tick();
        mode = MODE_FIXED; sel = 2'd0;
        repeat (3) tick();
        mode = MODE_RR;
        tick(); tick();
        chk_log("mode_sw_ch1", 1, 1, -1);
        chk_log("mode_sw_fixed", 4, 0, -1);
        chk_log("mode_sw_resume", 5, 2, 'hA2);

        // Three-channel build: out-of-range select grants nothing.
        in_valid3 = 3'b111; mode3 = MODE_FIXED; sel3 = 2'd3;
        #1;
        chk("n3_sel3_ready", 64'(in_ready3), 64'd0);
        @(posedge clk); #1;
        chk("n3_sel3_valid", 64'(out_valid3), 64'd0);
        sel3 = 2'd2;
        #1;
        chk("n3_sel2_ready", 64'(in_ready3), 64'b100);
        @(negedge clk);

        // Randomized traffic obeying the producer hold rule.
        do_reset();
        in_valid = '0;
        for (int c = 0; c < 1500; c++) begin
            tick();
            for (int k = 0; k < N; k++) begin
                if (in_valid[k]) begin
                    if (last_xfer == k) begin
                        in_valid[k] = 1'($urandom_range(0, 1));
                        set_data(k, 8'($urandom));
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    in_valid[k] = 1'b1;
                    set_data(k, 8'($urandom));
                end
            end
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            if ($urandom_range(0, 5) == 0) sel = SW'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
        in_valid  = '0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
